// File: rtl/mda_stream_reader_if.sv
// mda_stream_reader_if
// Output stream bundle of mda_stream_reader: one array element per
// valid/ready handshake, tagged with its row/column position.
//
// Signals:
//   o_valid   beat valid (driven by the reader)
//   o_ready   consumer ready (driven by the consumer)
//   o_data    element value, or the checksum on a checksum beat
//   o_row     row index of the beat
//   o_col     column index of the beat
//   o_tag     tag of the scan this beat belongs to
//   o_last    final beat of the scan
//   o_is_sum  beat carries the checksum rather than an element
//
// Modports: master = reader side, slave = consumer side.
interface mda_stream_reader_if #(
  parameter int ROWS = 2,
  parameter int COLS = 4,
  parameter int DW   = 11,
  parameter int TW   = 4
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic [RW-1:0] o_row;
  logic [CW-1:0] o_col;
  logic [TW-1:0] o_tag;
  logic          o_last;
  logic          o_is_sum;

  modport master (
    output o_valid, o_data, o_row, o_col, o_tag, o_last, o_is_sum,
    input  o_ready
  );

  modport slave (
    input  o_valid, o_data, o_row, o_col, o_tag, o_last, o_is_sum,
    output o_ready
  );
endinterface

// File: rtl/mda_stream_reader.sv
// mda_stream_reader
// Snapshots a ROWS x COLS array of DW-bit words on a start request and
// streams the elements out in row-major order (column fastest), one per
// valid/ready handshake, each tagged with its row/column and the scan tag.
//
// Ports:
//   clk     clock, all logic on the rising edge
//   rst     synchronous active-low reset
//   start   request a scan; only accepted while idle
//   i_tag   scan tag, captured with start
//   i_arr   flattened array, element [r][c] at bits [(r*COLS+c)*DW +: DW]
//   busy    high from the accepted start until the final handshake
//   done    one-cycle pulse after the final handshake
//   bus     output stream (mda_stream_reader_if.master)
//
// Optional feature: define MDA_STREAM_READER_CHECKSUM_EN to append one
// extra beat per scan carrying the sum of all elements modulo 2^DW.
module mda_stream_reader #(
  parameter int ROWS = 2,
  parameter int COLS = 4,
  parameter int DW   = 11,
  parameter int TW   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [TW-1:0]          i_tag,
  input  logic [ROWS*COLS*DW-1:0] i_arr,
  output logic                   busy,
  output logic                   done,
  mda_stream_reader_if.master    bus
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
`ifdef MDA_STREAM_READER_CHECKSUM_EN
  localparam logic [1:0] SUM  = 2'd2;
`endif

  logic [1:0]    state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [TW-1:0] tag_q;
  logic          done_q;
  logic [DW-1:0] snap [ROWS][COLS];
  logic          at_last;
  logic [DW-1:0] cur;
`ifdef MDA_STREAM_READER_CHECKSUM_EN
  logic [DW-1:0] sum_q;
`endif

  // Current element and end-of-array detection, shared by the state
  // machine and the output drive.
  assign cur     = snap[row][col];
  assign at_last = (row == LAST_ROW) && (col == LAST_COL);

  // Scan state machine. The array is copied whole on start so that the
  // producer may change i_arr freely while the scan is running. A handshake
  // in SEND/SUM is just o_ready, because o_valid is high in both states.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      row    <= '0;
      col    <= '0;
      tag_q  <= '0;
      done_q <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          snap[r][c] <= '0;
`ifdef MDA_STREAM_READER_CHECKSUM_EN
      sum_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int r = 0; r < ROWS; r++)
              for (int c = 0; c < COLS; c++)
                snap[r][c] <= i_arr[(r*COLS+c)*DW +: DW];
            tag_q <= i_tag;
            row   <= '0;
            col   <= '0;
`ifdef MDA_STREAM_READER_CHECKSUM_EN
            sum_q <= '0;
`endif
            state <= SEND;
          end
        end
        SEND: begin
          if (bus.o_ready) begin
`ifdef MDA_STREAM_READER_CHECKSUM_EN
            sum_q <= sum_q + cur;
`endif
            if (at_last) begin
`ifdef MDA_STREAM_READER_CHECKSUM_EN
              // Indices stay on the last element for the checksum beat.
              state <= SUM;
`else
              state  <= IDLE;
              done_q <= 1'b1;
              row    <= '0;
              col    <= '0;
`endif
            end else if (col == LAST_COL) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
`ifdef MDA_STREAM_READER_CHECKSUM_EN
        SUM: begin
          if (bus.o_ready) begin
            state  <= IDLE;
            done_q <= 1'b1;
            row    <= '0;
            col    <= '0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Stream outputs. Data/last are derived from registered state only, so
  // they are automatically stable while the consumer stalls.
  always_comb begin
    bus.o_valid  = 1'b0;
    bus.o_data   = '0;
    bus.o_last   = 1'b0;
    bus.o_is_sum = 1'b0;
    case (state)
      SEND: begin
        bus.o_valid = 1'b1;
        bus.o_data  = cur;
`ifdef MDA_STREAM_READER_CHECKSUM_EN
        bus.o_last  = 1'b0;
`else
        bus.o_last  = at_last;
`endif
      end
`ifdef MDA_STREAM_READER_CHECKSUM_EN
      SUM: begin
        bus.o_valid  = 1'b1;
        bus.o_data   = sum_q;
        bus.o_last   = 1'b1;
        bus.o_is_sum = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.o_row = row;
  assign bus.o_col = col;
  assign bus.o_tag = tag_q;
  assign busy      = (state != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_mda_stream_reader.sv
// tb_mda_stream_reader
// Directed bench for mda_stream_reader (2x4 array, 11-bit words).
// Inputs are driven and outputs sampled on the falling clock edge.
// Define MDA_STREAM_READER_CHECKSUM_EN for both RTL and bench to exercise
// the checksum beat.
module tb_mda_stream_reader;

  localparam int ROWS = 2;
  localparam int COLS = 4;
  localparam int DW   = 11;
  localparam int TW   = 4;
  localparam int NEL  = ROWS * COLS;
`ifdef MDA_STREAM_READER_CHECKSUM_EN
  localparam int NB   = NEL + 1;
`else
  localparam int NB   = NEL;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [TW-1:0]           i_tag;
  logic [ROWS*COLS*DW-1:0] i_arr;
  logic                    busy;
  logic                    done;

  logic [DW-1:0] exp_vals [NEL];

  int checks = 0;
  int errors = 0;

  mda_stream_reader_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .TW(TW)) bus ();

  mda_stream_reader #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .TW(TW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .i_tag (i_tag),
    .i_arr (i_arr),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  // 10 ns clock period.
  always #5 clk = ~clk;

  // Compare one observed value against its expectation and count it.
  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Pack the expected element table onto the array input.
  task automatic applyStimulus();
    for (int i = 0; i < NEL; i++)
      i_arr[i*DW +: DW] = exp_vals[i];
  endtask

  // Pulse start for one cycle; returns on the falling edge where the first
  // beat must already be visible.
  task automatic startScan(input logic [TW-1:0] tag);
    start = 1'b1;
    i_tag = tag;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consume one scan with o_ready following pat[cyc%4]. Every presented
  // beat is checked against the expected table, so a stalled beat must keep
  // matching the same entry. Optionally disturbs the inputs mid-scan.
  // Returns on the falling edge where done must be high.
  task automatic collectScan(input logic [3:0] pat, input logic [TW-1:0] tag, input bit disturb);
    int k = 0;
    int cyc = 0;
    logic [DW-1:0] sum = '0;
    for (int i = 0; i < NEL; i++) sum = sum + exp_vals[i];
    while (k < NB && cyc < 200) begin
      if (disturb && cyc == 0) i_arr = '1;
      if (disturb && cyc == 2) begin start = 1'b1; i_tag = 4'h5; end
      if (disturb && cyc == 3) start = 1'b0;
      bus.o_ready = pat[cyc % 4];
      if (cyc == 0) checkOutput("first_valid", {31'b0, bus.o_valid}, 32'd1);
      if (bus.o_valid) begin
        checkOutput("busy", {31'b0, busy}, 32'd1);
        checkOutput("tag", {28'b0, bus.o_tag}, {28'b0, tag});
        if (k < NEL) begin
          checkOutput("data", {21'b0, bus.o_data}, {21'b0, exp_vals[k]});
          checkOutput("row", {31'b0, bus.o_row}, k / COLS);
          checkOutput("col", {30'b0, bus.o_col}, k % COLS);
          checkOutput("is_sum", {31'b0, bus.o_is_sum}, 32'd0);
`ifdef MDA_STREAM_READER_CHECKSUM_EN
          checkOutput("last", {31'b0, bus.o_last}, 32'd0);
`else
          checkOutput("last", {31'b0, bus.o_last}, (k == NEL - 1) ? 32'd1 : 32'd0);
`endif
        end else begin
          checkOutput("sum_data", {21'b0, bus.o_data}, {21'b0, sum});
          checkOutput("sum_row", {31'b0, bus.o_row}, ROWS - 1);
          checkOutput("sum_col", {30'b0, bus.o_col}, COLS - 1);
          checkOutput("sum_flag", {31'b0, bus.o_is_sum}, 32'd1);
          checkOutput("sum_last", {31'b0, bus.o_last}, 32'd1);
        end
        if (bus.o_ready) k++;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput("beat_count", k, NB);
    bus.o_ready = 1'b0;
    checkOutput("end_valid", {31'b0, bus.o_valid}, 32'd0);
    checkOutput("end_busy", {31'b0, busy}, 32'd0);
    checkOutput("end_done", {31'b0, done}, 32'd1);
  endtask

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    i_tag       = '0;
    i_arr       = '0;
    bus.o_ready = 1'b0;
    for (int i = 0; i < NEL; i++)
      exp_vals[i] = DW'((i / COLS) * 16 + (i % COLS) + 1);

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_valid", {31'b0, bus.o_valid}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_last", {31'b0, bus.o_last}, 32'd0);
    checkOutput("rst_is_sum", {31'b0, bus.o_is_sum}, 32'd0);
    checkOutput("rst_data", {21'b0, bus.o_data}, 32'd0);
    checkOutput("rst_tag", {28'b0, bus.o_tag}, 32'd0);
    rst = 1'b1;

    // Full-rate scan.
    $display("[TB] scan with o_ready held high");
    applyStimulus();
    startScan(4'hA);
    collectScan(4'b1111, 4'hA, 1'b0);
    @(negedge clk);
    checkOutput("done_pulse_end", {31'b0, done}, 32'd0);
    checkOutput("idle_valid", {31'b0, bus.o_valid}, 32'd0);

    // Stalling consumer, then a start issued in the done cycle.
    $display("[TB] scan with o_ready pattern 1,0,0,1");
    startScan(4'hA);
    collectScan(4'b1001, 4'hA, 1'b0);
    $display("[TB] start in done cycle");
    startScan(4'hC);
    collectScan(4'b1111, 4'hC, 1'b0);

    // Array change after capture and a start while busy.
    $display("[TB] input disturbance during scan");
    @(negedge clk);
    startScan(4'hA);
    collectScan(4'b1111, 4'hA, 1'b1);
    @(negedge clk);
    checkOutput("no_restart", {31'b0, busy}, 32'd0);
    applyStimulus();

    // Reset during the third beat aborts the scan.
    $display("[TB] reset mid-scan");
    startScan(4'hA);
    bus.o_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("third_beat", {21'b0, bus.o_data}, 32'd3);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_valid", {31'b0, bus.o_valid}, 32'd0);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_done", {31'b0, done}, 32'd0);
    checkOutput("abort_row", {31'b0, bus.o_row}, 32'd0);
    checkOutput("abort_col", {30'b0, bus.o_col}, 32'd0);
    rst = 1'b1;
    bus.o_ready = 1'b0;
    startScan(4'hA);
    collectScan(4'b1111, 4'hA, 1'b0);

    // Uniform array; checksum wraps to zero when enabled.
    $display("[TB] uniform 0x400 array");
    for (int i = 0; i < NEL; i++) exp_vals[i] = 11'h400;
    applyStimulus();
    @(negedge clk);
    startScan(4'h3);
    collectScan(4'b1111, 4'h3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mda_stream_reader.md
Name: mda_stream_reader

Overview:
- Reader-side counterpart to the array-writing dut in the basic read/write test: consumes a multi-dimensional array the dut writes (2x4 grid of 11-bit words) and serialises it.
- On a start request, snapshots the whole array, then streams elements one per valid/ready handshake, tagged with row/column indices.
- Sits between an array-producing block and a stream consumer (e.g. a bus monitor or scoreboard port).

Parameters:
- ROWS, 2, number of rows (outer dimension), >=1
- COLS, 4, number of columns (inner dimension), >=1
- DW, 11, element width in bits
- TW, 4, request tag width
- RW, derived $clog2(ROWS) (min 1), row index width
- CW, derived $clog2(COLS) (min 1), column index width

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset
- start  input  1  request a scan; accepted only when idle
- i_tag  input  TW  request tag, captured with start
- i_arr  input  ROWS*COLS*DW  flattened array; element [r][c] at bits [(r*COLS+c)*DW +: DW]
- busy  output  1  high from accepted start until final handshake
- o_valid  output  1  stream beat valid
- o_ready  input  1  consumer ready
- o_data  output  DW  element value (or checksum, see option)
- o_row  output  RW  row index of beat
- o_col  output  CW  column index of beat
- o_tag  output  TW  tag of current scan
- o_last  output  1  final beat of scan
- o_is_sum  output  1  beat carries checksum (0 when option disabled)
- done  output  1  one-cycle pulse after final handshake

Behaviour:
- Reset (rst==0 at posedge): state IDLE; busy, o_valid, o_last, o_is_sum, done = 0; o_data, o_row, o_col, o_tag = 0; snapshot cleared. Reset mid-scan aborts immediately. No beat is completed in the reset cycle.
- FSM states: IDLE, SEND, (SUM with option), back to IDLE.
- IDLE: on start==1, capture i_arr into an internal snapshot and i_tag into o_tag; set row=col=0; go to SEND. The next cycle has busy=1 and o_valid=1 with element [0][0]. Latency from start to first valid is 1 cycle.
- Start while busy (SEND/SUM) is ignored. Changes to i_arr after capture do not affect the scan.
- SEND: o_data = snapshot[row][col]. A handshake occurs when o_valid&&o_ready; on a handshake, advance in row-major order, column fastest: col wraps COLS-1 to 0 with row+1.
- While o_valid&&!o_ready: o_data, o_row, o_col, o_last held stable. o_valid never drops without a handshake.
- o_last = 1 on beat [ROWS-1][COLS-1] (option off).
- Final handshake: next cycle o_valid=0, busy=0, done=1 for exactly one cycle, state IDLE.
- Start is accepted in the cycle done is high. Back-to-back scans therefore have a minimum 1 idle cycle between the final beat and the next first beat.
- o_ready is ignored when o_valid==0.
- Degenerate ROWS=COLS=1: single beat with o_last=1.
- Total beats per scan = ROWS*COLS (+1 with option). Throughput is 1 beat/cycle with o_ready held high.

Optional Feature:
- Macro MDA_STREAM_READER_CHECKSUM_EN.
- Defined:
  - A running sum of all sent elements is kept modulo 2^DW, cleared on start.
  - After beat [ROWS-1][COLS-1] handshakes, state SUM emits one extra beat: o_data=sum, o_is_sum=1, o_row/o_col = last indices, o_last=1. The last data beat has o_last=0.
  - done follows the SUM handshake.
- Undefined: no SUM state; o_is_sum tied 0; behaviour exactly as above.

Test Plan:
- Fill [r][c]=r*16+c+1 (1,2,3,4,17,18,19,20), i_tag=4'hA, pulse start, o_ready=1 -> beats 1..4,17..20 on consecutive cycles, indices (0,0)..(1,3), o_tag=A, o_last only on 20, done one cycle after.
- Same array, o_ready toggling 1,0,0,1 pattern -> each beat held while stalled, order unchanged, exactly 8 handshakes.
- Change i_arr to all 11'h7FF one cycle after start -> stream still emits the captured values 1..20; second start during scan ignored (still 8 beats, then idle).
- Deassert rst during third beat -> next cycle o_valid=0, busy=0, done=0; subsequent start restarts from (0,0).
- Option enabled, all elements 11'h400 -> 8 data beats with o_last=0, then checksum beat o_data=0 (8*0x400 mod 2^11), o_is_sum=1, o_last=1.
- Start asserted in done cycle -> first beat of new scan appears the following cycle.
